mips_ex_muldiv_ctrl: RTL and testbench
======================================

Name: mips_ex_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the ID/EX interface. Runs a radix-2 shift-add multiply or a restoring divide over MD_DATA_WIDTH cycles, then writes the HI/LO architectural registers. Drives a busy/stall indication to the pipeline control, and exposes HI/LO for MFHI/MFLO result selection in the EX result mux.

Parameters:
MD_DATA_WIDTH, `MIPS_DATA_WIDTH (32), operand and HI/LO width; also the iteration count.
MD_CNT_WIDTH, 5, iteration counter width; equals clog2(MD_DATA_WIDTH).

Ports:
clk  input  1  core clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
md_req_valid  input  1  request present from ID/EX
md_req_ready  output  1  controller can accept a request (state IDLE)
md_req_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
md_req_rs  input  MD_DATA_WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
md_req_rt  input  MD_DATA_WIDTH  rt operand: multiplier or divisor
md_flush  input  1  abort any in-flight operation (branch/exception squash)
md_busy  output  1  operation in flight; pipeline stalls MF*/MT*/MD requests
md_done  output  1  one-cycle pulse; HI/LO hold the new result this cycle
md_hi  output  MD_DATA_WIDTH  HI register value
md_lo  output  MD_DATA_WIDTH  LO register value

Behaviour:
- Accept: an edge with md_req_valid & md_req_ready & !md_flush.
- md_req_ready = (state==IDLE); md_busy = (state!=IDLE). Both are combinational from the state register.
- Reset: state IDLE, counter 0, md_hi=0, md_lo=0, md_done=0, and internal accumulators 0. Reset overrides every other input, including mid-operation.
- States:
  - IDLE: on accept of op 0-3, go to CALC with counter=0. On accept of op 4/5, write md_hi/md_lo = rs at that edge and stay in IDLE; no done pulse. On accept of op 6/7, consume the request with no effect.
  - CALC: one iteration per cycle. counter increments and wraps from MD_DATA_WIDTH-1 to 0 as the state moves to FIX. Exactly MD_DATA_WIDTH cycles are spent in CALC.
  - FIX: one cycle. Applies sign correction, writes HI/LO, sets md_done=1 (registered), then returns to IDLE.
  - In IDLE with md_done=1, a new request may be accepted in that same cycle.
- Latency: accept at edge E0. HI/LO update and md_done rise at edge E0+MD_DATA_WIDTH+1 (33 for 32-bit). md_done is high for exactly one cycle.
- Operand latch at accept: magnitudes |rs| and |rt| for signed ops (two's-complement negate if MSB=1), raw values for unsigned ops. Also latched: sign flags sq = rs[msb]^rt[msb] and sr = rs[msb], both forced 0 for unsigned ops.
- Multiply: 2*MD_DATA_WIDTH-bit product accumulator with shift-add on the multiplier LSB. Final {HI,LO} = sq ? -product : product, negated at full 2W width.
- Divide: restoring division using a (W+1)-bit trial subtract. LO = sq ? -quotient : quotient; HI = sr ? -remainder : remainder.
- Signed overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, which falls out of the magnitude arithmetic.
- Divide by zero (rt==0): HI = rs, LO = all ones. No sign correction is applied. Full latency still applies.
- Flush: md_flush in CALC or FIX sends the state to IDLE at the next edge. HI/LO are unchanged and md_done stays 0. md_flush in IDLE blocks acceptance that cycle, including MTHI/MTLO.
- Simultaneous events: rst beats md_flush, which beats accept. A request while busy is not consumed; the requester holds md_req_valid and operands stable until ready.
- md_hi/md_lo change only at MTHI/MTLO accept, at FIX, or at reset.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> md_done exactly 33 cycles after accept, HI=0xFFFFFFFE, LO=0x00000001; md_busy high for 33 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Back-to-back request accepted on the md_done cycle produces a correct second result.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100 rt=7 -> LO=14, HI=2.
- DIV rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU rs=5 rt=0 -> HI=5, LO=0xFFFFFFFF.
- Flush: preload HI=0x11, LO=0x22; start DIV; assert md_flush in CALC cycle 10 -> IDLE next edge, HI/LO still 0x11/0x22, no md_done. A following MULTU 3*4 gives LO=12.
- MTHI rs=0xABCD0000 in IDLE -> md_hi=0xABCD0000 after one edge, md_busy stays 0. MTLO issued while busy -> md_req_ready=0 and it completes only after md_done. rst at CALC cycle 5 -> HI=LO=0, IDLE, md_done never pulses.

Source files
------------

// File: rtl/mips_ex_muldiv_ctrl.sv
// mips_ex_muldiv_ctrl
// Iterative multiply/divide sequencer for the EX stage. Accepts MULT, MULTU,
// DIV, DIVU, MTHI and MTLO requests. Multiplies use radix-2 shift-add and
// divides use restoring division, one iteration per cycle over
// MD_DATA_WIDTH cycles. A single FIX cycle then applies sign correction and
// writes the HI/LO architectural registers.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   md_req_valid    request present from ID/EX
//   md_req_ready    controller idle, request can be accepted
//   md_req_op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//   md_req_rs/rt    operands
//   md_flush        abort any in-flight operation; blocks acceptance
//   md_busy         operation in flight
//   md_done         one-cycle pulse when HI/LO receive a new result
//   md_hi/md_lo     HI/LO register values
module mips_ex_muldiv_ctrl #(
  parameter int MD_DATA_WIDTH = 32,
  parameter int MD_CNT_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     md_req_valid,
  output logic                     md_req_ready,
  input  logic [2:0]               md_req_op,
  input  logic [MD_DATA_WIDTH-1:0] md_req_rs,
  input  logic [MD_DATA_WIDTH-1:0] md_req_rt,
  input  logic                     md_flush,
  output logic                     md_busy,
  output logic                     md_done,
  output logic [MD_DATA_WIDTH-1:0] md_hi,
  output logic [MD_DATA_WIDTH-1:0] md_lo
);

  localparam int W = MD_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state, state_nxt;
  logic [MD_CNT_WIDTH-1:0] cnt;
  logic                    is_div, sq, sr, div_zero;
  // Shared datapath: acc_hi is the product high half / partial remainder,
  // acc_lo the multiplier / dividend-quotient shift register, opnd_b the
  // multiplicand or divisor.
  logic [W-1:0]            acc_hi, acc_lo, opnd_b;

  logic                    accept, req_signed, req_div, last_iter;
  logic [W-1:0]            rs_mag, rt_mag;
  logic [W:0]              mul_sum, div_sh, div_diff;
  logic [2*W-1:0]          prod, prod_fix;
  logic [W-1:0]            fix_hi, fix_lo;

  assign md_req_ready = (state == IDLE);
  assign md_busy      = (state != IDLE);
  assign accept       = md_req_valid & md_req_ready & ~md_flush;
  assign last_iter    = (cnt == MD_CNT_WIDTH'(W - 1));

  always_comb begin
    req_signed = (md_req_op == 3'd0) || (md_req_op == 3'd2);
    req_div    = (md_req_op == 3'd2) || (md_req_op == 3'd3);
    rs_mag     = (req_signed && md_req_rs[W-1]) ? -md_req_rs : md_req_rs;
    rt_mag     = (req_signed && md_req_rt[W-1]) ? -md_req_rt : md_req_rt;
  end

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_sh   = {acc_hi, acc_lo[W-1]};
    div_diff = div_sh - {1'b0, opnd_b};
    prod     = {acc_hi, acc_lo};
    prod_fix = sq ? -prod : prod;
    fix_hi   = prod_fix[2*W-1:W];
    fix_lo   = prod_fix[W-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = opnd_b;
        fix_lo = '1;
      end else begin
        fix_hi = sr ? -acc_hi : acc_hi;
        fix_lo = sq ? -acc_lo : acc_lo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && !md_req_op[2]) state_nxt = CALC;
      CALC: begin
        if (md_flush)       state_nxt = IDLE;
        else if (last_iter) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      md_hi    <= '0;
      md_lo    <= '0;
      md_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (md_req_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                cnt      <= '0;
                is_div   <= req_div;
                sq       <= req_signed & (md_req_rs[W-1] ^ md_req_rt[W-1]);
                sr       <= req_signed & md_req_rs[W-1];
                div_zero <= req_div && (md_req_rt == '0);
                acc_hi   <= '0;
                if (req_div) begin
                  acc_lo <= rs_mag;
                  // A zero divisor is never used as one; opnd_b carries the
                  // raw dividend through to HI instead.
                  opnd_b <= (md_req_rt == '0) ? md_req_rs : rt_mag;
                end else begin
                  acc_lo <= rt_mag;
                  opnd_b <= rs_mag;
                end
              end
              3'd4:    md_hi <= md_req_rs;
              3'd5:    md_lo <= md_req_rs;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (!md_flush) begin
            cnt <= last_iter ? '0 : cnt + MD_CNT_WIDTH'(1);
            if (is_div) begin
              // No borrow from the (W+1)-bit trial means the divisor fits.
              if (!div_diff[W]) begin
                acc_hi <= div_diff[W-1:0];
                acc_lo <= {acc_lo[W-2:0], 1'b1};
              end else begin
                acc_hi <= div_sh[W-1:0];
                acc_lo <= {acc_lo[W-2:0], 1'b0};
              end
            end else begin
              acc_hi <= mul_sum[W:1];
              acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
            end
          end
        end
        FIX: begin
          if (!md_flush) begin
            md_hi   <= fix_hi;
            md_lo   <= fix_lo;
            md_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ex_muldiv_ctrl.sv
module tb_mips_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_req_valid;
  logic        md_req_ready;
  logic [2:0]  md_req_op;
  logic [31:0] md_req_rs, md_req_rt;
  logic        md_flush;
  logic        md_busy, md_done;
  logic [31:0] md_hi, md_lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mips_ex_muldiv_ctrl #(.MD_DATA_WIDTH(32), .MD_CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_op(md_req_op), .md_req_rs(md_req_rs), .md_req_rt(md_req_rt),
    .md_flush(md_flush), .md_busy(md_busy), .md_done(md_done),
    .md_hi(md_hi), .md_lo(md_lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural reference: HI/LO results from plain integer arithmetic.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] hi_in, input logic [31:0] lo_in,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    hi = hi_in;
    lo = lo_in;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'b0, rs} * {32'b0, rt}; hi = p[63:32]; lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (rt == 0) begin
          hi = rs;
          lo = '1;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          qv = 64'(q); rv = 64'(r);
          lo = qv[31:0]; hi = rv[31:0];
        end else begin
          lo = rs / rt; hi = rs % rt;
        end
      end
      3'd4: hi = rs;
      3'd5: lo = rs;
      default: ;
    endcase
  endtask

  // Issues one request from a point between edges; returns #1 after the
  // completing edge, so a following call is accepted on the md_done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int waited = 0;
    int lat = 0;
    int busy_n = 0;
    md_req_op = op; md_req_rs = rs; md_req_rt = rt; md_req_valid = 1'b1;
    while (!md_req_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (!md_req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
      md_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    md_req_valid = 1'b0;
    if (op < 3'd4) begin
      if (md_busy) busy_n++;
      while (!md_done && lat < 40) begin
        @(posedge clk); #1; lat++;
        if (md_busy) busy_n++;
      end
      chk("latency", 32'(lat), 32'd33);
      chk("busy_cycles", 32'(busy_n), 32'd33);
    end else begin
      chk("mt_busy", {31'b0, md_busy}, 32'd0);
      chk("mt_done", {31'b0, md_done}, 32'd0);
    end
    chk("hi", md_hi, exp_hi);
    chk("lo", md_lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic watch_no_done(input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (md_done) seen++;
    end
    chk("no_done", 32'(seen), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [2:0]  op;
    logic [31:0] rs, rt, eh, el;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[7] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{3'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E};

    rst = 1'b1; md_req_valid = 1'b0; md_req_op = '0;
    md_req_rs = '0; md_req_rt = '0; md_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, md_req_ready}, 32'd1);
    chk("rst_busy",  {31'b0, md_busy}, 32'd0);
    chk("rst_done",  {31'b0, md_done}, 32'd0);
    chk("rst_hi", md_hi, 32'd0);
    chk("rst_lo", md_lo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, issued back-to-back on each md_done cycle.
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

    @(posedge clk); #1;
    run_op(3'd4, 32'hABCD0000, 32'h0, 32'hABCD0000, m_lo);
    run_op(3'd6, 32'h12345678, 32'h9, m_hi, m_lo);

    // Flush in IDLE blocks MTHI.
    md_flush = 1'b1; md_req_op = 3'd4; md_req_rs = 32'hDEADBEEF; md_req_valid = 1'b1;
    @(posedge clk); #1;
    md_req_valid = 1'b0; md_flush = 1'b0;
    chk("idle_flush_hi", md_hi, m_hi);

    // Flush during CALC cycle 10.
    run_op(3'd4, 32'h11, 32'h0, 32'h11, m_lo);
    run_op(3'd5, 32'h22, 32'h0, 32'h11, 32'h22);
    md_req_op = 3'd2; md_req_rs = 32'hFFFFFFF9; md_req_rt = 32'd2; md_req_valid = 1'b1;
    @(posedge clk); #1;
    md_req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    md_flush = 1'b1;
    @(posedge clk); #1;
    md_flush = 1'b0;
    chk("flush_busy", {31'b0, md_busy}, 32'd0);
    chk("flush_hi", md_hi, 32'h11);
    chk("flush_lo", md_lo, 32'h22);
    watch_no_done(40);
    run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12);

    // MTLO while busy waits for the divide to finish.
    @(posedge clk); #1;
    md_req_op = 3'd3; md_req_rs = 32'd100; md_req_rt = 32'd7; md_req_valid = 1'b1;
    @(posedge clk); #1;
    md_req_op = 3'd5; md_req_rs = 32'h5555;
    chk("busy_ready", {31'b0, md_req_ready}, 32'd0);
    for (int i = 0; i < 40 && !md_done; i++) begin
      @(posedge clk); #1;
    end
    chk("mtlo_wait_done", {31'b0, md_done}, 32'd1);
    chk("mtlo_wait_lo", md_lo, 32'd14);
    @(posedge clk); #1;
    md_req_valid = 1'b0;
    chk("mtlo_lo", md_lo, 32'h5555);
    chk("mtlo_hi", md_hi, 32'd2);

    // Reset at CALC cycle 5.
    md_req_op = 3'd0; md_req_rs = 32'h1234; md_req_rt = 32'h5678; md_req_valid = 1'b1;
    @(posedge clk); #1;
    md_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_hi", md_hi, 32'd0);
    chk("mrst_lo", md_lo, 32'd0);
    chk("mrst_busy", {31'b0, md_busy}, 32'd0);
    watch_no_done(40);
    m_hi = '0; m_lo = '0;

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      case ($urandom_range(0, 5))
        0:       rt = 32'd0;
        1:       rt = 32'($urandom_range(1, 20));
        2:       rt = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        default: rt = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 1000));
      ref_model(op, rs, rt, m_hi, m_lo, eh, el);
      run_op(op, rs, rt, eh, el);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
